// File: rtl/sc_weight_bsgen_if.sv
// sc_weight_bsgen_if: start, weight-fold and bitstream handshake bundle for sc_weight_bsgen
interface sc_weight_bsgen_if #(
  parameter int DIM_IN = 4,
  parameter int DIM_OUT = 4,
  parameter int FOLD = 2,
  parameter int INWD = 3
);
  localparam int GRP = DIM_OUT / FOLD;
  localparam int FW = FOLD > 1 ? $clog2(FOLD) : 1;
  logic start, busy, done;
  logic w_valid, w_ready;
  logic [GRP*DIM_IN*INWD-1:0] w_in;
  logic bs_valid, bs_ready, bs_last;
  logic [GRP*DIM_IN-1:0] bs_out;
  logic [FW-1:0] fold_idx;
  modport master (
    output start, w_valid, w_in, bs_ready,
    input busy, done, w_ready, bs_valid, bs_out, fold_idx, bs_last
  );
  modport slave (
    input start, w_valid, w_in, bs_ready,
    output busy, done, w_ready, bs_valid, bs_out, fold_idx, bs_last
  );
endinterface

// File: rtl/sc_weight_bsgen.sv
// sc_weight_bsgen: folded stochastic-computing weight bitstream generator with shared RNG counter bank
module sc_weight_bsgen #(
  parameter int DIM_IN = 4,
  parameter int DIM_OUT = 4,
  parameter int FOLD = 2,
  parameter int INWD = 3,
  parameter int NUM_CNT = 4,
  parameter int CNT_MODE = 0
) (
  input logic clk,
  input logic rst,
  sc_weight_bsgen_if.slave io
);
  localparam int GRP = DIM_OUT / FOLD;
  localparam int GW = GRP * DIM_IN;
  localparam int FW = FOLD > 1 ? $clog2(FOLD) : 1;
  typedef enum logic [2:0] {IDLE, LOAD, RUN, DRAIN, FIN} state_e;
  state_e state_q, state_d;
  logic [FW-1:0] fold_q, fold_d, fidx_q, fidx_d;
  logic [INWD-1:0] t_q, t_d, cnt, rng;
  logic [GW*INWD-1:0] w_q, w_d;
  logic [GW-1:0] bs_q, bs_d, cmp;
  logic bsv_q, bsv_d, last_q, last_d, adv, last_fold;
  // counter k is (t + k) mod L, optionally bit-reversed; row j_g of column i reads counter (i + j_g) mod NUM_CNT
  always_comb begin
    cmp = '0;
    cnt = '0;
    rng = '0;
    for (int j = 0; j < GRP; j++)
      for (int i = 0; i < DIM_IN; i++) begin
        cnt = t_q + INWD'((i + j + int'(fold_q) * GRP) % NUM_CNT);
        for (int b = 0; b < INWD; b++) rng[b] = CNT_MODE != 0 ? cnt[INWD-1-b] : cnt[b];
        cmp[j*DIM_IN+i] = w_q[(j*DIM_IN+i)*INWD +: INWD] > rng;
      end
  end
  assign adv = !bsv_q || io.bs_ready;
  assign last_fold = fold_q == FW'(FOLD - 1);
  always_comb begin
    state_d = state_q;
    fold_d = fold_q;
    t_d = t_q;
    w_d = w_q;
    bs_d = bs_q;
    bsv_d = bsv_q;
    fidx_d = fidx_q;
    last_d = last_q;
    case (state_q)
      IDLE: begin
        state_d = io.start ? LOAD : IDLE;
        fold_d = io.start ? '0 : fold_q;
      end
      LOAD: if (io.w_valid) begin
        w_d = io.w_in;
        t_d = '0;
        state_d = RUN;
      end
      RUN: if (adv) begin
        bs_d = cmp;
        bsv_d = 1'b1;
        fidx_d = fold_q;
        last_d = &t_q;
        t_d = t_q + 1'b1;
        state_d = &t_q ? DRAIN : RUN;
      end
      DRAIN: if (io.bs_ready) begin
        bsv_d = 1'b0;
        state_d = last_fold ? FIN : LOAD;
        fold_d = last_fold ? fold_q : fold_q + 1'b1;
      end
      FIN: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      fold_q <= '0;
      t_q <= '0;
      w_q <= '0;
      bs_q <= '0;
      bsv_q <= 1'b0;
      fidx_q <= '0;
      last_q <= 1'b0;
    end else begin
      state_q <= state_d;
      fold_q <= fold_d;
      t_q <= t_d;
      w_q <= w_d;
      bs_q <= bs_d;
      bsv_q <= bsv_d;
      fidx_q <= fidx_d;
      last_q <= last_d;
    end
  end
  assign io.busy = state_q inside {LOAD, RUN, DRAIN};
  assign io.done = state_q == FIN;
  assign io.w_ready = state_q == LOAD;
  assign io.bs_valid = bsv_q;
  assign io.bs_out = bs_q;
  assign io.fold_idx = fidx_q;
  assign io.bs_last = last_q;
endmodule

// File: tb/tb_sc_weight_bsgen.sv
// tb_sc_weight_bsgen: scoreboard bench driving an up-counter and a bit-reversed instance in lockstep
module tb_sc_weight_bsgen;
  localparam int DIM_IN = 4, DIM_OUT = 4, FOLD = 2, INWD = 3, NUM_CNT = 4;
  localparam int GRP = DIM_OUT / FOLD, L = 1 << INWD, GW = GRP * DIM_IN, WW = GW * INWD;
  localparam int FW = FOLD > 1 ? $clog2(FOLD) : 1;
  typedef struct packed {logic [GW-1:0] bs; logic [FW-1:0] f; logic last;} exp_t;
  logic clk = 0, rst = 1, start = 0, w_valid = 0, bs_ready = 1;
  logic [WW-1:0] w_in = '0;
  always #5 clk = ~clk;
  sc_weight_bsgen_if #(.DIM_IN(DIM_IN), .DIM_OUT(DIM_OUT), .FOLD(FOLD), .INWD(INWD)) if0 (), if1 ();
  assign if0.start = start;
  assign if0.w_valid = w_valid;
  assign if0.w_in = w_in;
  assign if0.bs_ready = bs_ready;
  assign if1.start = start;
  assign if1.w_valid = w_valid;
  assign if1.w_in = w_in;
  assign if1.bs_ready = bs_ready;
  sc_weight_bsgen #(.DIM_IN(DIM_IN), .DIM_OUT(DIM_OUT), .FOLD(FOLD), .INWD(INWD), .NUM_CNT(NUM_CNT), .CNT_MODE(0))
    dut0 (.clk(clk), .rst(rst), .io(if0.slave));
  sc_weight_bsgen #(.DIM_IN(DIM_IN), .DIM_OUT(DIM_OUT), .FOLD(FOLD), .INWD(INWD), .NUM_CNT(NUM_CNT), .CNT_MODE(1))
    dut1 (.clk(clk), .rst(rst), .io(if1.slave));
  logic bv[2], bl[2], bz[2], wr[2], dn[2];
  logic [GW-1:0] bo[2];
  logic [FW-1:0] fi[2];
  assign bv[0] = if0.bs_valid;
  assign bl[0] = if0.bs_last;
  assign bz[0] = if0.busy;
  assign wr[0] = if0.w_ready;
  assign dn[0] = if0.done;
  assign bo[0] = if0.bs_out;
  assign fi[0] = if0.fold_idx;
  assign bv[1] = if1.bs_valid;
  assign bl[1] = if1.bs_last;
  assign bz[1] = if1.busy;
  assign wr[1] = if1.w_ready;
  assign dn[1] = if1.done;
  assign bo[1] = if1.bs_out;
  assign fi[1] = if1.fold_idx;
  int checks = 0, failures = 0, cyc = 0, acc_cnt = 0, acc_last_cyc = -10, done_cnt = 0, stall_n = 0;
  bit mon_en = 0, rdy_rand = 0, stall_job = 0, stalled = 0;
  exp_t q0[$], q1[$];
  logic [WW-1:0] wts[FOLD];
  logic p_stall[2];
  exp_t p_beat[2];
  int ones[2][GW];
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask
  function automatic logic [GW-1:0] ref_bits(input logic [WW-1:0] w, input int f, input int t, input int mode);
    logic [GW-1:0] r = '0;
    for (int s = 0; s < GW; s++) begin
      int j = s / DIM_IN;
      int i = s % DIM_IN;
      int v = (t + (i + f * GRP + j) % NUM_CNT) % L;
      int rn = 0;
      if (mode == 1) for (int b = 0; b < INWD; b++) rn = rn * 2 + ((v >> b) & 1);
      else rn = v;
      r[s] = int'(w[s*INWD +: INWD]) > rn;
    end
    return r;
  endfunction
  function automatic logic [WW-1:0] gen_w(input int kind, input int f);
    logic [WW-1:0] w = '0;
    for (int s = 0; s < GW; s++)
      w[s*INWD +: INWD] = kind == 0 ? INWD'(4) : kind == 1 ? (((s + f) % 2) != 0 ? INWD'(L - 1) : INWD'(0))
                        : INWD'($urandom_range(0, L - 1));
    return w;
  endfunction
  task automatic push_fold(input int f);
    for (int t = 0; t < L; t++) begin
      q0.push_back(exp_t'({ref_bits(wts[f], f, t, 0), FW'(f), t == L - 1}));
      q1.push_back(exp_t'({ref_bits(wts[f], f, t, 1), FW'(f), t == L - 1}));
    end
  endtask
  task automatic chk_idle(input string name);
    for (int m = 0; m < 2; m++)
      chk(name, 64'({bv[m], bl[m], bz[m], wr[m], dn[m], bo[m], fi[m]}), 64'(0));
  endtask
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    #1;
    if (stall_job && !stalled && acc_cnt == 3) begin
      stalled = 1;
      stall_n = 3;
    end
    if (stall_n > 0) begin
      bs_ready = 1'b0;
      stall_n--;
    end else bs_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
  end
  always @(negedge clk) if (mon_en) begin
    if (dn[0]) done_cnt++;
    for (int m = 0; m < 2; m++) begin
      exp_t cur, e;
      cur = exp_t'({bo[m], fi[m], bl[m]});
      if (p_stall[m]) begin
        chk("stall_valid_held", 64'(bv[m]), 64'(1));
        chk("stall_beat_held", 64'(cur), 64'(p_beat[m]));
      end
      if (bv[m] && bs_ready) begin
        if ((m == 0 ? q0.size() : q1.size()) == 0) chk("unexpected_beat", 64'(1), 64'(0));
        else begin
          e = m == 0 ? q0.pop_front() : q1.pop_front();
          chk(m == 0 ? "beat_mode0" : "beat_mode1", 64'(cur), 64'(e));
          for (int i = 0; i < GW; i++) ones[m][i] += int'(bo[m][i]);
          if (m == 0) begin
            acc_cnt++;
            if (bl[0] && fi[0] == FW'(FOLD - 1)) acc_last_cyc = cyc;
          end
          if (bl[m]) for (int i = 0; i < GW; i++) begin
            chk("stream_popcount", 64'(ones[m][i]), 64'(wts[fi[m]][i*INWD +: INWD]));
            ones[m][i] = 0;
          end
        end
      end
      p_stall[m] = bv[m] && !bs_ready;
      p_beat[m] = cur;
    end
  end
  task automatic run_job(input int kind, input int wdly, input bit xstart, input bit rrand, input bit stall);
    int n, dc;
    for (int f = 0; f < FOLD; f++) wts[f] = gen_w(kind, f);
    rdy_rand = rrand;
    stall_job = stall;
    stalled = 0;
    acc_cnt = 0;
    dc = done_cnt;
    start = 1;
    @(posedge clk) #1 start = 0;
    chk("busy_after_start", 64'(bz[0]), 64'(1));
    for (int f = 0; f < FOLD; f++) begin
      n = 0;
      while (!wr[0] && n < 200) begin
        @(posedge clk) #1;
        n++;
      end
      chk("w_ready_wait", 64'({wr[0], wr[1]}), 64'(3));
      for (int d = 0; d < wdly; d++) begin
        chk("load_wait_state", 64'({wr[0], wr[1], bv[0], bv[1]}), 64'(4'b1100));
        @(posedge clk) #1;
      end
      w_in = wts[f];
      w_valid = 1;
      push_fold(f);
      @(posedge clk) #1 w_valid = 0;
      chk("w_ready_drops", 64'({wr[0], wr[1]}), 64'(0));
      if (xstart && f == 0) begin
        start = 1;
        repeat (2) @(posedge clk);
        #1 start = 0;
      end
    end
    n = 0;
    while (!dn[0] && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", 64'({dn[0], dn[1]}), 64'(3));
    chk("done_after_last_beat", 64'(cyc - acc_last_cyc), 64'(1));
    chk("busy_low_with_done", 64'({bz[0], bz[1]}), 64'(0));
    chk("queues_drained", 64'(q0.size() + q1.size()), 64'(0));
    start = 1;
    @(posedge clk) #1 start = 0;
    chk("start_at_done_ignored", 64'({bz[0], wr[0]}), 64'(0));
    repeat (3) @(posedge clk);
    #1 chk("done_pulses_once", 64'(done_cnt - dc), 64'(1));
    stall_job = 0;
  endtask
  task automatic reset_mid_run();
    int n;
    wts[0] = gen_w(2, 0);
    rdy_rand = 0;
    acc_cnt = 0;
    start = 1;
    @(posedge clk) #1 start = 0;
    n = 0;
    while (!wr[0] && n < 50) begin
      @(posedge clk) #1;
      n++;
    end
    w_in = wts[0];
    w_valid = 1;
    push_fold(0);
    @(posedge clk) #1 w_valid = 0;
    n = 0;
    while (acc_cnt < 5 && n < 100) begin
      @(posedge clk) #1;
      n++;
    end
    chk("reached_beat5", 64'(acc_cnt >= 5), 64'(1));
    mon_en = 0;
    rst = 1;
    @(posedge clk) #1;
    chk_idle("reset_mid_run");
    rst = 0;
    q0.delete();
    q1.delete();
    for (int m = 0; m < 2; m++) begin
      p_stall[m] = 0;
      for (int i = 0; i < GW; i++) ones[m][i] = 0;
    end
    mon_en = 1;
    repeat (3) @(posedge clk);
    #1 chk("idle_after_reset", 64'({bz[0], bz[1], bv[0], bv[1]}), 64'(0));
  endtask
  initial begin
    for (int m = 0; m < 2; m++) begin
      p_stall[m] = 0;
      for (int i = 0; i < GW; i++) ones[m][i] = 0;
    end
    repeat (3) @(posedge clk);
    #1 chk_idle("reset_state");
    rst = 0;
    mon_en = 1;
    run_job(0, 0, 0, 0, 0);
    run_job(1, 0, 0, 0, 0);
    run_job(2, 5, 0, 0, 0);
    run_job(2, 0, 0, 0, 1);
    run_job(2, 0, 1, 1, 0);
    reset_mid_run();
    run_job(2, 0, 0, 1, 0);
    for (int r = 0; r < 4; r++) run_job(2, $urandom_range(0, 3), r[0], 1, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
endmodule
